grp_distributor_rr: RTL

- Parametrised successor to the fixed five-writer distributor in front of the ping-pong group buffers.
- N requesters (LCB packers, MCM packer, future sources) each raise busy and own one shared write/old-word-read port.
- Arbitration is round-robin with a watchdog timeout per grant.
- The writer-side bank select follows the frame former's switch, but a bank swap is deferred until no grant is active, so one transaction never spans both buffers.

---
 rtl/grp_distributor_rr.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/grp_distributor_rr.sv
// grp_distributor_rr
//   Round-robin distributor that lets N_CH packers share one write /
//   old-word-read port of the ping-pong group buffers. A grant is held
//   while the owner keeps busy high, up to TIMEOUT cycles, then forcibly
//   released. Every grant is followed by a one-cycle GAP. The writer-side
//   bank follows iSwitch but only swaps while no grant is active.
//
// Ports
//   clk, reset        80 MHz clock, asynchronous active-high reset
//   iBusy[N_CH]       per-channel request / hold
//   iWrData/iWrAddr   per-channel write word and address (packed by channel)
//   iWren[N_CH]       per-channel write enable
//   iRdAddr/iRdEn     per-channel old-word read address / enable
//   iSwitch           frame-former bank switch
//   iRdData           old-word data from the selected bank
//   oRdData           iRdData broadcast to every channel
//   oGrant            one-hot grant, zero when idle
//   oWrData/oWrAddr/oWren/oRdAddr/oRdEn  muxed port of the granted channel
//   oWrBank           writer-side bank (0 = MEM1, 1 = MEM2)
//   oSwitchPend       requested bank not yet applied
//   oTimeout          one-cycle pulse on forced release
//   oTimeoutCh        channel last forcibly released
module grp_distributor_rr #(
    parameter int N_CH    = 5,
    parameter int DW      = 12,
    parameter int AW      = 10,
    parameter int TIMEOUT = 1023,
    parameter int CW      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      iBusy,
    input  logic [N_CH*DW-1:0]   iWrData,
    input  logic [N_CH*AW-1:0]   iWrAddr,
    input  logic [N_CH-1:0]      iWren,
    input  logic [N_CH*AW-1:0]   iRdAddr,
    input  logic [N_CH-1:0]      iRdEn,
    input  logic                 iSwitch,
    input  logic [DW-1:0]        iRdData,
    output logic [DW-1:0]        oRdData,
    output logic [N_CH-1:0]      oGrant,
    output logic [DW-1:0]        oWrData,
    output logic [AW-1:0]        oWrAddr,
    output logic                 oWren,
    output logic [AW-1:0]        oRdAddr,
    output logic                 oRdEn,
    output logic                 oWrBank,
    output logic                 oSwitchPend,
    output logic                 oTimeout,
    output logic [CW-1:0]        oTimeoutCh
);

    localparam int unsigned   NCH_U    = N_CH;
    localparam int            CNTW     = $clog2(TIMEOUT) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LAST_RST = CW'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     gidx;        // granted channel index
    logic [CW-1:0]     last;        // round-robin pointer
    logic [CW-1:0]     pick;
    logic              pick_vld;
    logic [N_CH-1:0]   mask;        // channels released by watchdog
    logic [N_CH-1:0]   elig;
    logic [CNTW-1:0]   cnt;
    logic              busy_g, wren_g, rden_g;
    logic [DW-1:0]     wrdata_g;
    logic [AW-1:0]     wraddr_g, rdaddr_g;
    logic              tmo_n;
    logic              bank_upd;

    assign oRdData = iRdData;

    // First eligible channel searching last+1, last+2, ... modulo N_CH.
    always_comb begin
        elig     = iBusy & ~mask;
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 1; i <= NCH_U; i++) begin
            int unsigned cand;
            cand = 32'(last) + i;
            if (cand >= NCH_U) cand = cand - NCH_U;
            for (int unsigned k = 0; k < NCH_U; k++) begin
                if (!pick_vld && elig[k] && cand == k) begin
                    pick     = CW'(k);
                    pick_vld = 1'b1;
                end
            end
        end
    end

    // Signals of the currently indexed channel.
    always_comb begin
        busy_g   = 1'b0;
        wren_g   = 1'b0;
        rden_g   = 1'b0;
        wrdata_g = '0;
        wraddr_g = '0;
        rdaddr_g = '0;
        for (int unsigned k = 0; k < NCH_U; k++) begin
            if (gidx == CW'(k)) begin
                busy_g   = iBusy[k];
                wren_g   = iWren[k];
                rden_g   = iRdEn[k];
                wrdata_g = iWrData[k*DW +: DW];
                wraddr_g = iWrAddr[k*AW +: AW];
                rdaddr_g = iRdAddr[k*AW +: AW];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // FSM: next state. Busy fall wins over a simultaneous watchdog expiry.
    always_comb begin
        state_n = state;
        tmo_n   = 1'b0;
        case (state)
            IDLE:  if (pick_vld) state_n = GRANT;
            GRANT: begin
                if (!busy_g) begin
                    state_n = GAP;
                end else if (cnt == CNT_LAST) begin
                    state_n = GAP;
                    tmo_n   = 1'b1;
                end
            end
            GAP:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        oGrant  = '0;
        oWren   = 1'b0;
        oRdEn   = 1'b0;
        oWrData = '0;
        oWrAddr = '0;
        oRdAddr = '0;
        if (state == GRANT) begin
            for (int unsigned k = 0; k < NCH_U; k++)
                oGrant[k] = (gidx == CW'(k));
            oWren   = wren_g;
            oRdEn   = rden_g;
            oWrData = wrdata_g;
            oWrAddr = wraddr_g;
            oRdAddr = rdaddr_g;
        end
    end

    // Bank may also swap on the edge that ends a grant, so it is already
    // applied during the GAP cycle; it never swaps between two GRANT cycles.
    assign bank_upd = !(state == GRANT && state_n == GRANT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gidx        <= '0;
            last        <= LAST_RST;
            cnt         <= '0;
            mask        <= '0;
            oWrBank     <= 1'b0;
            oSwitchPend <= 1'b0;
            oTimeout    <= 1'b0;
            oTimeoutCh  <= '0;
        end else begin
            oTimeout <= tmo_n;
            mask     <= (mask & iBusy) | (tmo_n ? oGrant : '0);
            if (state == IDLE && pick_vld) begin
                gidx <= pick;
                cnt  <= '0;
            end
            if (state == GRANT) begin
                cnt <= cnt + CNTW'(1);
                if (state_n == GAP) last <= gidx;
                if (tmo_n) oTimeoutCh <= gidx;
            end
            if (bank_upd) begin
                oWrBank     <= ~iSwitch;
                oSwitchPend <= 1'b0;
            end else begin
                oSwitchPend <= (oWrBank == iSwitch);
            end
        end
    end

endmodule
